dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit memory words.
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the wait cycles between accept and response; legal range is 0..15.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  1  the core presents a request.
REQ-006 req_ready  output  1  the responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 req_unsigned  input  1  zero-extend load data (LBU/LHU) instead of sign-extending.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 rsp_valid  output  1  one-cycle response pulse.
REQ-013 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  the request was rejected; qualified by rsp_valid.

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE and SHALL NOT be 1 in any other state or during the rst cycle.
REQ-017 A request is accepted on a cycle with req_valid=1 and req_ready=1.
- On accept, the block SHALL latch req_we, req_size, req_unsigned, req_addr and req_wdata.
- If LATENCY>0, the block SHALL load a counter with LATENCY and go to BUSY.
- If LATENCY=0, the block SHALL go directly to RESP.
REQ-018 In BUSY, the counter SHALL decrement each cycle. On the cycle the counter equals 1, the next state SHALL be RESP.
REQ-019 In RESP, rsp_valid SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE. Latched-request fields and rsp_rdata/rsp_err SHALL be held stable while rsp_valid=1.
REQ-020 A request accepted at cycle N SHALL produce rsp_valid at cycle N+LATENCY+1. Back-to-back throughput SHALL be one request per LATENCY+2 cycles.
REQ-021 Error detection:
- rsp_err SHALL be 1 if req_size=11.
- rsp_err SHALL be 1 if a half access has addr[0]=1.
- rsp_err SHALL be 1 if a word access has addr[1:0]!=00.
- rsp_err SHALL be 1 if addr[31:2] >= DEPTH_WORDS.
- An erroring store SHALL NOT modify memory. An erroring load SHALL return rsp_rdata=0.
REQ-022 Store commit:
- The memory write SHALL occur on the BUSY->RESP or IDLE->RESP transition edge, never earlier.
- Byte stores SHALL write lane addr[1:0] only.
- Half stores SHALL write lanes {addr[1],0} and {addr[1],1} only.
- Word stores SHALL write all four lanes.
- Unwritten lanes SHALL be preserved.
REQ-023 Load data:
- The memory word SHALL be read at addr[31:2].
- The block SHALL select the byte or half lane by addr[1:0] and shift it to bit 0.
- The block SHALL sign-extend, or zero-extend if req_unsigned=1. Word loads SHALL be returned unmodified.
REQ-024 Memory is little-endian: byte lane k SHALL occupy bits [8k+7:8k].
REQ-025 req_* inputs SHALL be ignored outside the accept cycle. Changes to them during BUSY/RESP SHALL NOT affect the in-flight response.

Reset
REQ-026 While rst=1, the block SHALL force state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0 and latched fields=0.
REQ-027 On the first cycle after rst deasserts, req_ready SHALL be 1.
REQ-028 rst asserted while in BUSY SHALL abort the request: no memory write and no rsp_valid.
REQ-029 rst asserted on a RESP cycle SHALL force rsp_valid to 0. A store already committed on the preceding edge SHALL remain in memory.
REQ-030 Memory contents SHALL NOT be cleared by rst.

Verification
REQ-031 Scenario, word round trip (LATENCY=2): SW 0xDEADBEEF to 0x10 accepted at cycle 0 -> rsp_valid at cycle 3 with err=0. Then LW 0x10 -> rsp_rdata=0xDEADBEEF.
REQ-032 Scenario, sub-word stores and loads: after the word round trip, SB 0x80 to 0x12.
- LB 0x12 -> 0xFFFFFF80.
- LBU 0x12 -> 0x00000080.
- LH 0x12 -> 0xFFFFDE80.
- LW 0x10 -> 0xDE80BEEF.
REQ-033 Scenario, misaligned and out-of-range accesses:
- SH to 0x11 -> rsp_err=1 and memory unchanged.
- LW 0x13 -> rsp_err=1, rsp_rdata=0.
- LW DEPTH_WORDS*4 -> rsp_err=1.
- size=11 -> rsp_err=1.
REQ-034 Scenario, handshake: hold req_valid=1 continuously -> req_ready is 0 for LATENCY+1 cycles after each accept. Exactly one rsp_valid per accept. Input changes during BUSY do not alter the response.
REQ-035 Scenario, reset mid-operation: SW 0x12345678 to 0x20, then pulse rst in BUSY -> no rsp_valid. LW 0x20 returns the prior contents. req_ready=1 one cycle after rst falls.
REQ-036 Scenario, LATENCY=0 build: accept at cycle N -> rsp_valid at N+1. Alternating SW/LW to 0x0 returns the just-stored value.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-port data-memory responder: accepts one load/store, waits LATENCY
// cycles, then returns one response pulse with extended load data or an error.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [3:0]  cnt_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        commit;
    logic        mem_we;

    logic        cur_we;
    logic [1:0]  cur_size;
    logic        cur_uns;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;

    logic [IDX_W-1:0] word_idx;
    logic             in_range;
    logic             bad_align;
    logic             err;

    logic [31:0] rd_word;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;
    logic [3:0]  be;
    logic [31:0] wdata_rep;

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) state_d = RESP;
                    else              state_d = BUSY;
                end
            end
            BUSY:    if (cnt_q == 4'd1) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The response is produced on the edge that enters RESP.
    assign commit = (state_d == RESP) && (state_q != RESP);

    // With zero latency the commit edge is the accept edge, so use the live request.
    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = req_we;
            cur_size  = req_size;
            cur_uns   = req_unsigned;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end else begin
            cur_we    = we_q;
            cur_size  = size_q;
            cur_uns   = uns_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    // ------------------------------------------------------------------
    // Error detection
    // ------------------------------------------------------------------
    assign word_idx = cur_addr[IDX_W+1:2];
    assign in_range = {2'b00, cur_addr[31:2]} < 32'(DEPTH_WORDS);

    always_comb begin
        bad_align = 1'b0;
        case (cur_size)
            SZ_BYTE: bad_align = 1'b0;
            SZ_HALF: bad_align = cur_addr[0];
            SZ_WORD: bad_align = |cur_addr[1:0];
            default: bad_align = 1'b1;
        endcase
    end

    assign err = bad_align || !in_range;

    // ------------------------------------------------------------------
    // Load path: lane select, shift to bit 0, extend
    // ------------------------------------------------------------------
    assign rd_word = mem[word_idx];

    always_comb begin
        lane_byte = rd_word[7:0];
        case (cur_addr[1:0])
            2'd0: lane_byte = rd_word[7:0];
            2'd1: lane_byte = rd_word[15:8];
            2'd2: lane_byte = rd_word[23:16];
            2'd3: lane_byte = rd_word[31:24];
            default: lane_byte = rd_word[7:0];
        endcase
        lane_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

        load_data = '0;
        case (cur_size)
            SZ_BYTE: load_data = {{24{~cur_uns & lane_byte[7]}}, lane_byte};
            SZ_HALF: load_data = {{16{~cur_uns & lane_half[15]}}, lane_half};
            SZ_WORD: load_data = rd_word;
            default: load_data = '0;
        endcase
        if (err || cur_we) load_data = '0;
    end

    // ------------------------------------------------------------------
    // Store path: byte enables and lane-replicated write data
    // ------------------------------------------------------------------
    always_comb begin
        be        = 4'b0000;
        wdata_rep = cur_wdata;
        case (cur_size)
            SZ_BYTE: begin
                be        = 4'b0001 << cur_addr[1:0];
                wdata_rep = {4{cur_wdata[7:0]}};
            end
            SZ_HALF: begin
                be        = cur_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{cur_wdata[15:0]}};
            end
            SZ_WORD: begin
                be        = 4'b1111;
                wdata_rep = cur_wdata;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = cur_wdata;
            end
        endcase
    end

    assign mem_we = commit && cur_we && !err && !rst;

    // NOTE: the storage array has no reset; contents survive rst and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[word_idx][8*k +: 8] <= wdata_rep[8*k +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Request latch, latency counter and response registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt_q   <= LAT;
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q - 4'd1;
            end
            rsp_valid_q <= commit;
            rsp_rdata_q <= commit ? load_data : '0;
            rsp_err_q   <= commit && err;
        end
    end

    // Reset is synchronous, so gate the registered response to kill it during a rst cycle.
    assign rsp_valid = rsp_valid_q && !rst;
    assign rsp_rdata = rst ? '0 : rsp_rdata_q;
    assign rsp_err   = rsp_err_q && !rst;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance and a LATENCY=0
// instance, with expected responses queued at accept and checked on rsp_valid.
module tb_dmem_responder;

    localparam int LAT    = 2;
    localparam int DEPTH  = 1024;
    localparam int DEPTH0 = 16;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        d0_req_valid, d0_req_ready, d0_req_we, d0_req_unsigned;
    logic [1:0]  d0_req_size;
    logic [31:0] d0_req_addr, d0_req_wdata;
    logic        d0_rsp_valid, d0_rsp_err;
    logic [31:0] d0_rsp_rdata;

    exp_t sb_q[$];
    exp_t sb0_q[$];
    exp_t hs_e;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] v;

    logic [31:0] hs_addr [3] = '{32'h10, 32'h12, 32'h12};
    logic [1:0]  hs_size [3] = '{SZ_W, SZ_B, SZ_H};
    logic        hs_uns  [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] hs_exp  [3] = '{32'hDE80BEEF, 32'h00000080, 32'hFFFFDE80};

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH0), .LATENCY(0)) dut0 (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (d0_req_valid),
        .req_ready    (d0_req_ready),
        .req_we       (d0_req_we),
        .req_size     (d0_req_size),
        .req_unsigned (d0_req_unsigned),
        .req_addr     (d0_req_addr),
        .req_wdata    (d0_req_wdata),
        .rsp_valid    (d0_rsp_valid),
        .rsp_rdata    (d0_rsp_rdata),
        .rsp_err      (d0_rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and score any response either instance shows.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rsp_valid === 1'b1) begin
            chk("rsp_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_cycle", cyc, e.due);
            end
        end
        if (d0_rsp_valid === 1'b1) begin
            chk("d0_rsp_expected", 32'(sb0_q.size() != 0), 32'd1);
            if (sb0_q.size() != 0) begin
                e = sb0_q.pop_front();
                chk("d0_rsp_rdata", d0_rsp_rdata, e.rdata);
                chk("d0_rsp_err", 32'(d0_rsp_err), 32'(e.err));
                chk("d0_rsp_cycle", cyc, e.due);
            end
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
        int   n;
        exp_t e;
        n = 0;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        while (req_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("ready_wait", 32'(n < 40), 32'd1);
        e.rdata = exp_rd; e.err = exp_err; e.due = cyc + LAT + 1;
        sb_q.push_back(e);
        tick();
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    endtask

    task automatic issue0(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err);
        int   n;
        exp_t e;
        n = 0;
        d0_req_valid = 1'b1; d0_req_we = we; d0_req_size = sz; d0_req_unsigned = uns;
        d0_req_addr = addr; d0_req_wdata = wd;
        while (d0_req_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("d0_ready_wait", 32'(n < 40), 32'd1);
        e.rdata = exp_rd; e.err = exp_err; e.due = cyc + 1;
        sb0_q.push_back(e);
        tick();
        chk("d0_ready_in_resp", 32'(d0_req_ready), 32'd0);
        d0_req_valid = 1'b0; d0_req_we = 1'($urandom); d0_req_addr = $urandom;
        d0_req_wdata = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || sb0_q.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n < 50), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish by 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_size = SZ_W; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        d0_req_valid = 1'b0; d0_req_we = 1'b0; d0_req_size = SZ_W; d0_req_unsigned = 1'b0;
        d0_req_addr = '0; d0_req_wdata = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("d0_rst_ready", 32'(d0_req_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 32'(req_ready), 32'd1);
        chk("d0_ready_after_rst", 32'(d0_req_ready), 32'd1);

        // Word round trip
        issue(1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Sub-word store; upper wdata bits must be ignored
        issue(1'b1, SZ_B, 1'b0, 32'h12, 32'h12345680, 32'h0, 1'b0);
        issue(1'b0, SZ_B, 1'b0, 32'h12, 32'h0, 32'hFFFFFF80, 1'b0);
        issue(1'b0, SZ_B, 1'b1, 32'h12, 32'h0, 32'h00000080, 1'b0);
        issue(1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 32'hFFFFDE80, 1'b0);
        issue(1'b0, SZ_H, 1'b1, 32'h12, 32'h0, 32'h0000DE80, 1'b0);
        issue(1'b0, SZ_H, 1'b0, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
        issue(1'b0, SZ_B, 1'b1, 32'h11, 32'h0, 32'h000000BE, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDE80BEEF, 1'b0);
        drain();

        // Handshake: valid held high, inputs scrambled while busy
        tick();
        req_valid = 1'b1; req_we = 1'b0; req_size = hs_size[0];
        req_unsigned = hs_uns[0]; req_addr = hs_addr[0]; req_wdata = '0;
        for (int k = 0; k < 3; k++) begin
            chk("hs_ready_high", 32'(req_ready), 32'd1);
            hs_e.rdata = hs_exp[k]; hs_e.err = 1'b0; hs_e.due = cyc + LAT + 1;
            sb_q.push_back(hs_e);
            for (int i = 1; i <= LAT + 1; i++) begin
                tick();
                chk("hs_ready_low", 32'(req_ready), 32'd0);
                if (i <= LAT) begin
                    req_we = 1'b1; req_size = SZ_W; req_addr = 32'h10;
                    req_wdata = $urandom; req_unsigned = 1'($urandom);
                end else if (k < 2) begin
                    req_we = 1'b0; req_size = hs_size[k+1]; req_unsigned = hs_uns[k+1];
                    req_addr = hs_addr[k+1]; req_wdata = '0;
                end else begin
                    req_valid = 1'b0;
                end
            end
            tick();
        end
        drain();

        // Misaligned, out-of-range and illegal-size accesses
        issue(1'b1, SZ_H, 1'b0, 32'h11, 32'h0000FFFF, 32'h0, 1'b1);
        issue(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDE80BEEF, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
        issue(1'b0, SZ_W, 1'b0, 32'(DEPTH * 4), 32'h0, 32'h0, 1'b1);
        issue(1'b1, SZ_W, 1'b0, 32'(DEPTH * 4), 32'h11111111, 32'h0, 1'b1);
        issue(1'b0, SZ_X, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
        issue(1'b1, SZ_X, 1'b0, 32'h10, 32'h55555555, 32'h0, 1'b1);
        issue(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDE80BEEF, 1'b0);
        issue(1'b1, SZ_H, 1'b0, 32'h12, 32'hABCD1234, 32'h0, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0);
        drain();

        // Reset while busy aborts the store
        issue(1'b1, SZ_W, 1'b0, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0);
        drain();
        tick();
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_W; req_addr = 32'h20;
        req_wdata = 32'h12345678;
        chk("rb_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("rb_ready_in_rst", 32'(req_ready), 32'd0);
        chk("rb_rsp_valid_in_rst", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        tick();
        chk("rb_ready_after_rst", 32'(req_ready), 32'd1);
        repeat (4) tick();
        issue(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0);
        drain();

        // Reset on the response cycle: pulse suppressed, store kept
        tick();
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_W; req_addr = 32'h24;
        req_wdata = 32'h0BADF00D;
        chk("rr_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        tick();
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        chk("rr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rr_rsp_rdata", rsp_rdata, 32'd0);
        rst = 1'b0;
        tick();
        chk("rr_ready_after_rst", 32'(req_ready), 32'd1);
        issue(1'b0, SZ_W, 1'b0, 32'h24, 32'h0, 32'h0BADF00D, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0);
        drain();

        // Zero-latency instance: alternating store/load at address 0
        for (int k = 0; k < 4; k++) begin
            v = $urandom;
            issue0(1'b1, SZ_W, 1'b0, 32'h0, v, 32'h0, 1'b0);
            issue0(1'b0, SZ_W, 1'b0, 32'h0, 32'h0, v, 1'b0);
        end
        issue0(1'b1, SZ_B, 1'b0, 32'h3, 32'h0000009A, 32'h0, 1'b0);
        issue0(1'b0, SZ_B, 1'b0, 32'h3, 32'h0, 32'hFFFFFF9A, 1'b0);
        issue0(1'b0, SZ_W, 1'b0, 32'h0, 32'h0, {8'h9A, v[23:0]}, 1'b0);
        issue0(1'b0, SZ_W, 1'b0, 32'(DEPTH0 * 4), 32'h0, 32'h0, 1'b1);
        drain();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
